// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants and butterfly mode encoding
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_Q_W = 12;
  typedef enum logic {BF_MODE_CT = 1'b0, BF_MODE_GS = 1'b1} bf_mode_e;
endpackage

// File: rtl/mod_mul_pipe.sv
// mod_mul_pipe: (a*b) mod Q on plain residues with a fixed MUL_LAT latency and shared enable
module mod_mul_pipe
  import kyber_pkg::*;
#(
  parameter int Q_W = KYBER_Q_W,
  parameter int Q = KYBER_Q,
  parameter int MUL_LAT = 2
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_en,
  input  logic [Q_W-1:0] i_a,
  input  logic [Q_W-1:0] i_b,
  output logic [Q_W-1:0] o_p
);
  logic [2*Q_W-1:0] prod;
  logic [Q_W-1:0] r [MUL_LAT];
  assign prod = (2*Q_W)'(i_a) * (2*Q_W)'(i_b);
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r <= '{default: '0};
    end else if (i_en) begin
      r[0] <= Q_W'(prod % (2*Q_W)'(Q));
      for (int i = 1; i < MUL_LAT; i++) r[i] <= r[i-1];
    end
  end
  assign o_p = r[MUL_LAT-1];
endmodule

// File: rtl/butterfly_core_pipe.sv
// butterfly_core_pipe: pipelined CT/GS butterfly with tag pass-through and stall
module butterfly_core_pipe
  import kyber_pkg::*;
#(
  parameter int Q_W = KYBER_Q_W,
  parameter int Q = KYBER_Q,
  parameter int MUL_LAT = 2,
  parameter int TAG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  input  logic             i_mode,
  input  logic [Q_W-1:0]   i_x,
  input  logic [Q_W-1:0]   i_y,
  input  logic [Q_W-1:0]   i_zeta,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_stall,
  output logic             o_valid,
  output logic [Q_W-1:0]   o_z_h,
  output logic [Q_W-1:0]   o_z_l,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);
  localparam logic [Q_W:0] QE = (Q_W+1)'(Q);
  function automatic logic [Q_W-1:0] add_mod(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
    logic [Q_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= QE) ? Q_W'(s - QE) : s[Q_W-1:0];
  endfunction
  function automatic logic [Q_W-1:0] sub_mod(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
    logic [Q_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[Q_W] ? Q_W'(d + QE) : d[Q_W-1:0];
  endfunction
  logic en;
  bf_mode_e mode_in, m;
  logic [MUL_LAT-1:0] vld;
  bf_mode_e mode [MUL_LAT];
  logic [TAG_W-1:0] tag [MUL_LAT];
  logic [Q_W-1:0] hd [MUL_LAT];
  logic [Q_W-1:0] mul_a, t, h;
  assign en = !i_stall;
  assign mode_in = bf_mode_e'(i_mode);
  // GS diff is formed ahead of the multiplier so both modes occupy the same multiplier slot
  assign mul_a = (mode_in == BF_MODE_GS) ? sub_mod(i_x, i_y) : i_y;
  assign h = hd[MUL_LAT-1];
  assign m = mode[MUL_LAT-1];
  mod_mul_pipe #(.Q_W(Q_W), .Q(Q), .MUL_LAT(MUL_LAT)) u_mul (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_en   (en),
    .i_a    (mul_a),
    .i_b    (i_zeta),
    .o_p    (t)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      vld <= '0;
      mode <= '{default: BF_MODE_CT};
      tag <= '{default: '0};
      hd <= '{default: '0};
      o_valid <= 1'b0;
      o_z_h <= '0;
      o_z_l <= '0;
      o_tag <= '0;
      o_busy <= 1'b0;
    end else if (en) begin
      vld[0] <= i_valid;
      mode[0] <= mode_in;
      tag[0] <= i_tag;
      hd[0] <= (mode_in == BF_MODE_GS) ? add_mod(i_x, i_y) : i_x;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld[i] <= vld[i-1];
        mode[i] <= mode[i-1];
        tag[i] <= tag[i-1];
        hd[i] <= hd[i-1];
      end
      o_valid <= vld[MUL_LAT-1];
      o_z_h <= !vld[MUL_LAT-1] ? '0 : (m == BF_MODE_GS) ? h : add_mod(h, t);
      o_z_l <= !vld[MUL_LAT-1] ? '0 : (m == BF_MODE_GS) ? t : sub_mod(h, t);
      o_tag <= vld[MUL_LAT-1] ? tag[MUL_LAT-1] : '0;
      // equals the OR of every valid bit after this edge, output stage included
      o_busy <= i_valid | (|vld);
    end
  end
endmodule

// File: doc/butterfly_core_pipe.md
Name: butterfly_core_pipe

Overview:
- Parametrised, fully pipelined successor of the Kyber butterfly unit.
- Supports both NTT (Cooley-Tukey) and INTT (Gentleman-Sande) butterflies, selected per sample.
- Accepts one butterfly per cycle under a valid/stall handshake and carries an address tag alongside each sample.
- Sits between the coefficient RAM read ports and the write-back logic of the NTT/INTT engine.

Parameters:
- Q_W, 12, coefficient width in bits.
- Q, 3329, modulus; must satisfy Q < 2^Q_W.
- MUL_LAT, 2, modular multiplier pipeline depth in cycles (>=1).
- TAG_W, 8, width of the pass-through tag (RAM write address).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_valid  in  1  input sample valid.
- i_mode  in  1  0 = CT/NTT, 1 = GS/INTT.
- i_x  in  Q_W  upper operand, range [0,Q-1].
- i_y  in  Q_W  lower operand, range [0,Q-1].
- i_zeta  in  Q_W  twiddle, plain residue, range [0,Q-1].
- i_tag  in  TAG_W  tag, returned unchanged with the result.
- i_stall  in  1  1 = freeze the entire pipeline.
- o_valid  out  1  result valid.
- o_z_h  out  Q_W  upper result.
- o_z_l  out  Q_W  lower result.
- o_tag  out  TAG_W  tag of the result.
- o_busy  out  1  any valid sample in flight.

Behaviour:
- Reset: sampled at the rising i_clk edge while i_rstn=0. Clears all pipeline valid bits and all data/tag registers. After reset: o_valid=0, o_z_h=0, o_z_l=0, o_tag=0, o_busy=0. A reset mid-operation drops every in-flight sample; nothing is emitted afterwards for those samples.
- Arithmetic, all results in [0,Q-1]:
  - CT: t=(y*zeta) mod Q; z_h=(x+t) mod Q; z_l=(x-t) mod Q.
  - GS: z_h=(x+y) mod Q; z_l=((x-y) mod Q * zeta) mod Q.
  - Add/sub use Q_W+1 bit intermediates with a single conditional ±Q correction. Barrett reduction is not needed.
- Latency: L = MUL_LAT+1 cycles from input acceptance to o_valid, identical for both modes.
  - CT: multiply first (MUL_LAT stages). x is delayed MUL_LAT stages to align, then one registered add/sub stage.
  - GS: one registered add/sub stage, then the diff is multiplied over MUL_LAT stages. The sum is delayed MUL_LAT stages to align.
  - One shared multiplier per lane. The operand mux is selected by the per-stage mode bit.
- Mode, tag and valid travel with each sample in a shift pipeline of length L. CT and GS samples may be interleaved back-to-back with no bubble.
- Throughput: one sample per non-stalled cycle.
- Stall: when i_stall=1, every pipeline register holds, and o_valid/o_z_*/o_tag hold their values.
  - An input with i_valid=1 during a stall is not accepted. The source must hold it until a cycle with i_stall=0.
  - o_valid=1 during a stall means the same result is repeated. The consumer must qualify o_valid with !i_stall.
- Outputs are registered. When o_valid=0, o_z_h, o_z_l and o_tag are forced to 0.
- o_busy = OR of all pipeline valid bits, registered.
- Out-of-range inputs (>=Q): outputs are unspecified but still < 2^Q_W. No lock-up.
- The pipeline contains no state machine, so no deadlock is possible; liveness depends only on i_stall.

Decomposition:
- Shared package kyber_pkg holds:
  - constants KYBER_Q=3329 and KYBER_Q_W=12;
  - the mode encoding BF_MODE_CT=0 and BF_MODE_GS=1.
- One sub-module, mod_mul_pipe, with parameters Q_W, Q, MUL_LAT:
  - computes (a*b) mod Q with a fixed latency of MUL_LAT and a shared stall/enable;
  - may use Montgomery internally, provided the conversion constants are folded in so the port semantics stay plain residues.
- The butterfly core holds the align delays, add/sub stages, tag/valid pipeline and o_busy.

Test Plan:
- Reset, then CT x=1,y=1,zeta=1 -> after L=3 cycles: o_valid=1, o_z_h=2, o_z_l=0, tag echoed.
- CT x=0,y=1,zeta=3328 -> o_z_h=3328, o_z_l=1; and CT x=3328,y=3328,zeta=3328 -> t=1, o_z_h=0, o_z_l=3327.
- GS x=5,y=10,zeta=2 -> o_z_h=15, o_z_l=3319; and GS x=3328,y=3328,zeta=7 -> o_z_h=3327, o_z_l=0.
- 100 back-to-back random samples with alternating modes, tags 0..99 -> outputs in order, one per cycle, matching the reference model.
- i_stall=1 for 4 cycles mid-stream -> outputs frozen, no sample lost or duplicated (qualified by !i_stall), order preserved.
- Drop i_rstn for 1 cycle with 3 samples in flight -> o_valid stays 0 afterwards, o_busy=0 the cycle after reset.
